// File: rtl/seg_pid_gen.sv
// Balance controller: saturated P+I+D steering effort from pitch and pitch rate,
// two-stage registered pipeline with soft-start magnitude clamp and integrator-saturation flag.
module seg_pid_gen #(
    parameter int ERR_W   = 10,
    parameter int OUT_W   = 12,
    parameter int P_COEFF = 9,
    parameter int INT_W   = 18,
    parameter int I_SHIFT = 6,
    parameter int D_SHIFT = 6,
    parameter int TMR_W   = 27,
    parameter int SS_W    = 8,
    parameter int TMR_INC = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    vld,
    input  logic signed [15:0]      ptch,
    input  logic signed [15:0]      ptch_rt,
    input  logic                    pwr_up,
    input  logic                    rider_off,
    output logic signed [OUT_W-1:0] PID_cntrl,
    output logic                    cntrl_vld,
    output logic [SS_W-1:0]         ss_tmr,
    output logic                    ss_done,
    output logic                    int_sat
);

    localparam int PW    = ERR_W + 6;
    localparam int DW    = 17;
    localparam int MW0   = (PW > DW) ? PW : DW;
    localparam int MW    = (MW0 > INT_W) ? MW0 : INT_W;
    localparam int SUM_W = MW + 2;

    localparam logic signed [15:0]      ERR_MAX = 16'((2 ** (ERR_W - 1)) - 1);
    localparam logic signed [15:0]      ERR_MIN = 16'(-(2 ** (ERR_W - 1)));
    localparam logic signed [SUM_W-1:0] OUT_MAX = SUM_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] OUT_MIN = SUM_W'(-(2 ** (OUT_W - 1)));
    localparam logic signed [PW-1:0]    P_GAIN  = PW'(P_COEFF);

    function automatic logic signed [ERR_W-1:0] sat_err(input logic signed [15:0] v);
        if (v > ERR_MAX)
            return ERR_MAX[ERR_W-1:0];
        else if (v < ERR_MIN)
            return ERR_MIN[ERR_W-1:0];
        else
            return v[ERR_W-1:0];
    endfunction

    function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [SUM_W-1:0] v);
        if (v > OUT_MAX)
            return OUT_MAX[OUT_W-1:0];
        else if (v < OUT_MIN)
            return OUT_MIN[OUT_W-1:0];
        else
            return v[OUT_W-1:0];
    endfunction

    function automatic logic signed [OUT_W-1:0] clamp_mag(input logic signed [OUT_W-1:0] v,
                                                          input logic signed [OUT_W-1:0] lim);
        if (v > lim)
            return lim;
        else if (v < -lim)
            return -lim;
        else
            return v;
    endfunction

    logic signed [ERR_W-1:0] err;
    logic signed [PW-1:0]    p_calc;
    logic signed [DW-1:0]    d_calc;
    logic signed [INT_W-1:0] err_ext;
    logic signed [INT_W-1:0] integ;
    logic signed [INT_W-1:0] integ_nxt;
    logic                    integ_ovf;

    logic signed [PW-1:0]    p_p0;
    logic signed [DW-1:0]    d_p0;
    logic                    vld_p0;

    logic signed [SUM_W-1:0] sum_p1;
    logic signed [OUT_W-1:0] sat_p1;
    logic signed [OUT_W-1:0] limit_p1;
    logic signed [OUT_W-1:0] res_p1;

    logic [TMR_W-1:0]        tmr;

    assign err       = sat_err(ptch);
    assign p_calc    = PW'(err) * P_GAIN;
    assign d_calc    = -(DW'(ptch_rt >>> D_SHIFT));
    assign err_ext   = INT_W'(err);
    assign integ_nxt = integ + err_ext;
    // Two's-complement overflow: like-signed operands producing an opposite-signed sum.
    assign integ_ovf = (integ[INT_W-1] == err_ext[INT_W-1]) &&
                       (integ_nxt[INT_W-1] != integ[INT_W-1]);

    // ---- stage 1: capture P/D terms, update integrator ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0  <= 1'b0;
            p_p0    <= '0;
            d_p0    <= '0;
            integ   <= '0;
            int_sat <= 1'b0;
        end else begin
            vld_p0 <= vld;
            if (vld) begin
                p_p0 <= p_calc;
                d_p0 <= d_calc;
            end
            if (rider_off) begin
                integ   <= '0;
                int_sat <= 1'b0;
            end else if (vld) begin
                if (integ_ovf)
                    int_sat <= 1'b1;
                else
                    integ <= integ_nxt;
            end
        end
    end

    assign sum_p1   = SUM_W'(p_p0) + SUM_W'(integ >>> I_SHIFT) + SUM_W'(d_p0);
    assign sat_p1   = sat_out(sum_p1);
    assign limit_p1 = signed'(OUT_W'(ss_tmr) << (OUT_W - 1 - SS_W));
    assign res_p1   = ss_done ? sat_p1 : clamp_mag(sat_p1, limit_p1);

    // ---- stage 2: sum, saturate, soft-start clamp, register output ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PID_cntrl <= '0;
            cntrl_vld <= 1'b0;
        end else begin
            cntrl_vld <= vld_p0;
            if (vld_p0)
                PID_cntrl <= res_p1;
        end
    end

    // Soft-start timer freezes once its visible top bits saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tmr <= '0;
        else if (!pwr_up)
            tmr <= '0;
        else if (!ss_done)
            tmr <= tmr + TMR_W'(TMR_INC);
    end

    assign ss_tmr  = tmr[TMR_W-1 -: SS_W];
    assign ss_done = &ss_tmr;

endmodule

// File: tb/tb_seg_pid_gen.sv
// Bench for seg_pid_gen: three instances (fast-timer default, short soft-start timer, P_COEFF=0)
// with a per-instance scoreboard of expected results and due cycles.
module tb_seg_pid_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, pwr_up, rider_off;
    logic vld_a, vld_b, vld_c;
    logic signed [15:0] ptch, ptch_rt;
    logic signed [11:0] pid_a, pid_b, pid_c;
    logic cv_a, cv_b, cv_c;
    logic [7:0] ss_tmr_a, ss_tmr_b, ss_tmr_c;
    logic ss_done_a, ss_done_b, ss_done_c;
    logic int_sat_a, int_sat_b, int_sat_c;

    seg_pid_gen #(.TMR_INC(524288)) dut_a (
        .clk(clk), .rst_n(rst_n), .vld(vld_a), .ptch(ptch), .ptch_rt(ptch_rt),
        .pwr_up(pwr_up), .rider_off(rider_off), .PID_cntrl(pid_a), .cntrl_vld(cv_a),
        .ss_tmr(ss_tmr_a), .ss_done(ss_done_a), .int_sat(int_sat_a));

    seg_pid_gen #(.TMR_W(11), .SS_W(8), .TMR_INC(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .vld(vld_b), .ptch(ptch), .ptch_rt(ptch_rt),
        .pwr_up(pwr_up), .rider_off(rider_off), .PID_cntrl(pid_b), .cntrl_vld(cv_b),
        .ss_tmr(ss_tmr_b), .ss_done(ss_done_b), .int_sat(int_sat_b));

    seg_pid_gen #(.P_COEFF(0), .TMR_INC(524288)) dut_c (
        .clk(clk), .rst_n(rst_n), .vld(vld_c), .ptch(ptch), .ptch_rt(ptch_rt),
        .pwr_up(pwr_up), .rider_off(rider_off), .PID_cntrl(pid_c), .cntrl_vld(cv_c),
        .ss_tmr(ss_tmr_c), .ss_done(ss_done_c), .int_sat(int_sat_c));

    typedef struct {
        int    val;
        int    due;
        string nm;
    } exp_t;

    typedef struct {
        logic signed [15:0] p;
        logic signed [15:0] r;
        int                 exp;
    } vec_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];
    vec_t tbl[10];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input int d, input int val, input string nm);
        exp_t e;
        e.val = val;
        e.due = cyc + 2;
        e.nm  = nm;
        case (d)
            0: q_a.push_back(e);
            1: q_b.push_back(e);
            default: q_c.push_back(e);
        endcase
    endtask

    task automatic pop_exp(input int d, output exp_t e, output bit ok);
        ok = 1'b0;
        e.val = 0; e.due = 0; e.nm = "";
        case (d)
            0: if (q_a.size() > 0) begin e = q_a.pop_front(); ok = 1'b1; end
            1: if (q_b.size() > 0) begin e = q_b.pop_front(); ok = 1'b1; end
            default: if (q_c.size() > 0) begin e = q_c.pop_front(); ok = 1'b1; end
        endcase
    endtask

    logic cv [3];
    int   pidv [3];
    assign cv[0] = cv_a;
    assign cv[1] = cv_b;
    assign cv[2] = cv_c;
    assign pidv[0] = int'(pid_a);
    assign pidv[1] = int'(pid_b);
    assign pidv[2] = int'(pid_c);

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (cv[d]) begin
                exp_t e;
                bit   ok;
                pop_exp(d, e, ok);
                if (!ok)
                    check($sformatf("unexpected_cntrl_vld_dut%0d", d), 1, 0);
                else begin
                    check(e.nm, pidv[d], e.val);
                    check({e.nm, "_latency"}, cyc, e.due);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; pwr_up = 1'b0; rider_off = 1'b0;
        vld_a = 1'b0; vld_b = 1'b0; vld_c = 1'b0;
        ptch = '0; ptch_rt = '0;

        tbl[0] = '{16'sd100,    16'sd0,     901};
        tbl[1] = '{16'sh7FFF,   16'sd0,     2047};
        tbl[2] = '{16'sh8000,   16'sd0,    -2048};
        tbl[3] = '{16'sd0,      16'sh1000, -64};
        tbl[4] = '{-16'sd100,   16'sd0,    -902};
        tbl[5] = '{16'sd200,   -16'sd640,   1813};
        tbl[6] = '{16'sd0,      16'sh8000,  512};
        tbl[7] = '{-16'sd30,    16'sh7FFF, -782};
        tbl[8] = '{16'sd227,    16'sd0,     2046};
        tbl[9] = '{16'sd228,    16'sd0,     2047};

        repeat (3) @(negedge clk);
        check("rst_pid",     int'(pid_a), 0);
        check("rst_vld",     int'(cv_a), 0);
        check("rst_ss_tmr",  int'(ss_tmr_a), 0);
        check("rst_ss_done", int'(ss_done_a), 0);
        check("rst_int_sat", int'(int_sat_a), 0);

        rst_n = 1'b1; pwr_up = 1'b1;
        repeat (40) @(negedge clk);
        check("ss_tmr_b_at_40", int'(ss_tmr_b), 5);
        check("ss_tmr_a_at_40", int'(ss_tmr_a), 40);

        vld_b = 1'b1; ptch = 16'sd100; push(1, 40, "softstart_pos");
        @(negedge clk);
        ptch = -16'sd100; push(1, -40, "softstart_neg");
        @(negedge clk);
        vld_b = 1'b0; ptch = '0;

        repeat (260) @(negedge clk);
        check("ss_done_a", int'(ss_done_a), 1);
        check("ss_tmr_a_full", int'(ss_tmr_a), 255);
        check("ss_done_b_early", int'(ss_done_b), 0);

        for (int i = 0; i < 10; i++) begin
            rider_off = 1'b1;
            @(negedge clk);
            rider_off = 1'b0; vld_a = 1'b1;
            ptch = tbl[i].p; ptch_rt = tbl[i].r;
            push(0, tbl[i].exp, $sformatf("vec%0d", i));
            @(negedge clk);
            vld_a = 1'b0;
        end

        rider_off = 1'b1;
        @(negedge clk);
        rider_off = 1'b0; ptch_rt = '0; ptch = 16'sd100; vld_a = 1'b1;
        push(0, 901, "b2b_0"); @(negedge clk);
        push(0, 903, "b2b_1"); @(negedge clk);
        push(0, 904, "b2b_2"); @(negedge clk);
        rider_off = 1'b1; push(0, 900, "rider_off_with_vld");
        @(negedge clk);
        vld_a = 1'b0; rider_off = 1'b0; ptch = '0;
        repeat (3) @(negedge clk);

        rider_off = 1'b1;
        @(negedge clk);
        rider_off = 1'b0; ptch = 16'sh7FFF; ptch_rt = '0; vld_c = 1'b1;
        for (int k = 1; k <= 257; k++) begin
            if (k == 257) check("int_sat_after_256", int'(int_sat_c), 0);
            push(2, (k <= 256) ? (511 * k) / 64 : 2044, $sformatf("integ_%0d", k));
            @(negedge clk);
        end
        vld_c = 1'b0;
        check("int_sat_after_257", int'(int_sat_c), 1);
        ptch = '0; vld_c = 1'b1; push(2, 2044, "integ_hold");
        @(negedge clk);
        vld_c = 1'b0;
        @(negedge clk);
        rider_off = 1'b1;
        @(negedge clk);
        rider_off = 1'b0;
        check("int_sat_cleared", int'(int_sat_c), 0);
        vld_c = 1'b1; push(2, 0, "integ_cleared");
        @(negedge clk);
        vld_c = 1'b0;

        repeat (2100) @(negedge clk);
        check("ss_done_b", int'(ss_done_b), 1);
        check("ss_tmr_b_full", int'(ss_tmr_b), 255);
        vld_b = 1'b1; ptch = 16'sd100; push(1, 901, "softstart_released");
        @(negedge clk);
        vld_b = 1'b0; ptch = '0;
        repeat (3) @(negedge clk);

        vld_a = 1'b1; ptch = 16'sd100;
        @(negedge clk);
        vld_a = 1'b0; ptch = '0;
        rst_n = 1'b0;
        #1;
        check("midrst_pid",     int'(pid_a), 0);
        check("midrst_vld",     int'(cv_a), 0);
        check("midrst_ss_tmr",  int'(ss_tmr_a), 0);
        check("midrst_ss_done", int'(ss_done_a), 0);
        check("midrst_int_sat", int'(int_sat_c), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("no_vld_after_rst", int'(cv_a), 0);
        end

        repeat (300) @(negedge clk);
        check("ss_done_a_again", int'(ss_done_a), 1);
        vld_a = 1'b1; ptch = 16'sd100; push(0, 901, "post_rst_result");
        @(negedge clk);
        vld_a = 1'b0;
        @(negedge clk);
        pwr_up = 1'b0;
        @(negedge clk);
        check("pwr_drop_ss_tmr", int'(ss_tmr_a), 0);
        check("pwr_drop_ss_done", int'(ss_done_a), 0);
        vld_a = 1'b1; ptch = 16'sd100; push(0, 0, "pwr_drop_clamped");
        @(negedge clk);
        vld_a = 1'b0; ptch = '0;
        repeat (4) @(negedge clk);

        check("pending_a", q_a.size(), 0);
        check("pending_b", q_b.size(), 0);
        check("pending_c", q_c.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_pid_gen.md
# seg_pid_gen

Parametrised second-generation balance controller for the Segway datapath, sitting between the inertial sensor interface and the motor-drive mixer. It computes a saturated P+I+D steering effort from pitch and pitch rate on each valid sample. It adds three things: a registered two-stage pipeline with an output-valid strobe, a soft-start magnitude clamp driven by the power-up timer, and an integrator-saturation flag. Widths, gains, shifts and timer rate are parameters.

## Interface
- ERR_W, 10, width of the saturated pitch error (signed)
- OUT_W, 12, width of PID_cntrl (signed)
- P_COEFF, 9, unsigned proportional gain, 0..15
- INT_W, 18, integrator width (signed)
- I_SHIFT, 6, arithmetic right shift applied to the integrator to form the I term
- D_SHIFT, 6, arithmetic right shift applied to ptch_rt to form the D term, before negation
- TMR_W, 27, soft-start long timer width
- SS_W, 8, ss_tmr width (top bits of the long timer)
- TMR_INC, 1, long-timer increment per clk; must be ≤ 2^(TMR_W-SS_W)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- vld  in  1  new ptch/ptch_rt sample, one-cycle strobe
- ptch  in  16  signed pitch
- ptch_rt  in  16  signed pitch rate
- pwr_up  in  1  level; low holds soft-start timer at 0
- rider_off  in  1  level; clears integrator and int_sat
- PID_cntrl  out  OUT_W  signed registered control effort
- cntrl_vld  out  1  one-cycle strobe, PID_cntrl updated
- ss_tmr  out  SS_W  soft-start progress
- ss_done  out  1  ss_tmr all ones
- int_sat  out  1  sticky, integrator overflow hold has occurred

## Operation
- err = ptch saturated to ERR_W signed: above 2^(ERR_W-1)-1 gives max; below -2^(ERR_W-1) gives min.
- Stage 1, on the clk edge where vld=1:
  - register err, P = P_COEFF*err at full width, and D = -(ptch_rt >>> D_SHIFT).
  - integrator += sign-extended err.
  - Overflow: both operands have the same sign and the sum's sign differs. On overflow the integrator holds and int_sat is set.
- rider_off=1: integrator←0 and int_sat←0 on that edge; this overrides the vld update. Stage 1 still captures P and D.
- Stage 2, on the edge after stage 1:
  - sum = P + (integrator >>> I_SHIFT) + D at full precision, with no intermediate wrap.
  - Saturate sum to OUT_W.
  - Soft-start clamp applies while ss_done=0: limit = ss_tmr << (OUT_W-1-SS_W), and the result is clamped to [-limit, +limit].
  - Register the result as PID_cntrl and pulse cntrl_vld.
- Long timer:
  - pwr_up=0: cleared to 0.
  - Otherwise it increments by TMR_INC each clk until its top SS_W bits are all ones, then freezes.
  - ss_tmr = top SS_W bits. ss_done is combinational from ss_tmr.
- PID_cntrl holds its value between updates.

## Timing
- Reset values: PID_cntrl=0, cntrl_vld=0, ss_tmr=0, ss_done=0, int_sat=0. Integrator and stage-1 registers are also 0.
- Latency: vld sampled at edge N; PID_cntrl and cntrl_vld change at edge N+1, visible 2 edges after vld is presented. cntrl_vld is high for exactly one cycle.
- Back-to-back vld is supported at full rate, one result per cycle, in order.
- The stage-2 clamp uses ss_tmr as of edge N+1.
- pwr_up falling: ss_tmr=0 on the next edge, so any later result is clamped to 0.
- rider_off and vld on the same edge: the integrator ends at 0. The result emitted at N+1 uses integrator=0.
- Async reset mid-pipeline: an in-flight sample is discarded and no cntrl_vld is generated.

## Test plan
- P path (defaults, timer pre-run to ss_done, integrator 0): ptch=100, ptch_rt=0, one vld → 2 edges later PID_cntrl=901 (900 + (100>>>6)), cntrl_vld one cycle.
- Saturation: ptch=0x7FFF → err=511, P=4599 → PID_cntrl=0x7FF. Then ptch=0x8000 → PID_cntrl=0x800.
- D path: ptch=0, ptch_rt=0x1000, integrator 0 → PID_cntrl=-64 (0xFC0).
- Soft-start (TMR_W=11, SS_W=8): when ss_tmr=5, ptch=100 → PID_cntrl=40; ptch=-100 → -40. When ss_done=1 the clamp is released.
- Integrator (P_COEFF=0, ptch=0x7FFF, continuous vld):
  - After 256 samples integrator=130816 and int_sat=0.
  - On the 257th sample it holds 130816 and int_sat=1.
  - rider_off pulse → integrator 0, int_sat 0.
- Reset/power: assert rst_n low between vld and result → no cntrl_vld and all outputs 0. Drop pwr_up mid-run → ss_tmr=0 next edge and subsequent PID_cntrl=0.
